// File: rtl/module_control_unit_pkg.sv
// Shared encodings for the control unit: FSM states, opcodes, instruction field layout.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package module_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_OFF           = 3'b000,
        ST_FETCH         = 3'b001,
        ST_DECODE        = 3'b010,
        ST_CALC          = 3'b011,
        ST_DISPLAY_STORE = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'b000,
        OP_ADD     = 3'b001,
        OP_ADDI    = 3'b010,
        OP_SUB     = 3'b011,
        OP_SUBI    = 3'b100,
        OP_MUL     = 3'b101,
        OP_CLEAR   = 3'b110,
        OP_DISPLAY = 3'b111
    } opcode_t;

    localparam int INSTR_W  = 18;
    localparam int OPC_MSB  = 17;
    localparam int OPC_LSB  = 15;
    localparam int DST_MSB  = 14;
    localparam int DST_LSB  = 11;
    localparam int SRC1_MSB = 10;
    localparam int SRC1_LSB = 7;
    localparam int SRC2_MSB = 6;
    localparam int SRC2_LSB = 3;
    localparam int SIGN_BIT = 6;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;

    localparam logic [3:0] LAST_ADDR = 4'hF;

    typedef struct packed {
        logic [2:0] opcode;
        logic       sinal;
        logic [5:0] imm;
        logic [3:0] addr1;
        logic [3:0] addr2;
        logic [3:0] addr_wr;
    } fields_t;

    // Register ops use src1/src2; everything else takes the sign/immediate split.
    function automatic fields_t decode_instr(input logic [INSTR_W-1:0] instr);
        fields_t f;
        f.opcode  = instr[OPC_MSB:OPC_LSB];
        f.addr_wr = instr[DST_MSB:DST_LSB];
        f.addr1   = instr[SRC1_MSB:SRC1_LSB];
        f.addr2   = 4'h0;
        f.sinal   = instr[SIGN_BIT];
        f.imm     = instr[IMM_MSB:IMM_LSB];
        case (opcode_t'(instr[OPC_MSB:OPC_LSB]))
            OP_ADD, OP_SUB: begin
                f.addr2 = instr[SRC2_MSB:SRC2_LSB];
                f.sinal = 1'b0;
                f.imm   = 6'h00;
            end
            OP_LOAD:    f.addr1   = 4'h0;
            OP_DISPLAY: f.addr_wr = instr[SRC1_MSB:SRC1_LSB];
            default:    ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/module_control_unit_hs_timer.sv
// Handshake watchdog: counts cycles spent waiting in a state, flags expiry at HS_TIMEOUT cycles.
// Latency: start clears the count at the next edge; expired is a decode of the registered count.
// Backpressure: none; done freezes the count, the count saturates at the expiry value.
module module_hs_timer #(
    parameter int HS_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam int CW = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(HS_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (!done && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Count holds cycles already elapsed in the state, so expiry falls on the last allowed cycle.
    assign expired = (cnt == LAST);

endmodule

// File: rtl/module_control_unit.sv
// CPU control FSM: latches an instruction, sequences ALU handshakes, drives RAM write / LCD refresh.
// Latency: send->ram_we = 1 + decode wait + calc wait cycles (5 with one-cycle ALU acks).
// Backpressure: send accepted only in FETCH, dropped elsewhere; handshake waits abort after HS_TIMEOUT.
module module_control_unit
    import module_control_unit_pkg::*;
#(
    parameter int HS_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power,
    input  logic        send,
    input  logic [17:0] instr,
    input  logic        decoded,
    input  logic        calculated,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  addr_wr,
    output logic        ram_we,
    output logic        lcd_update,
    output logic        err
);

    state_t  state;
    fields_t dec;
    logic    timer_start;
    logic    timer_done;
    logic    timer_expired;

    assign dec         = decode_instr(instr);
    assign timer_start = ((state == ST_FETCH) && send) || ((state == ST_DECODE) && decoded);
    assign timer_done  = (state == ST_CALC) && calculated;
    assign stateCPU    = state;

    module_hs_timer #(
        .HS_TIMEOUT (HS_TIMEOUT)
    ) u_hs_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (timer_start),
        .done    (timer_done),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            opcode     <= 3'b000;
            sinalImm   <= 1'b0;
            Imm        <= 6'h00;
            addr1      <= 4'h0;
            addr2      <= 4'h0;
            addr_wr    <= 4'h0;
            ram_we     <= 1'b0;
            lcd_update <= 1'b0;
            err        <= 1'b0;
        end else if (power && (state != ST_OFF)) begin
            // Power-off outranks any handshake or send seen in the same cycle.
            state      <= ST_OFF;
            opcode     <= 3'b000;
            sinalImm   <= 1'b0;
            Imm        <= 6'h00;
            addr1      <= 4'h0;
            addr2      <= 4'h0;
            addr_wr    <= 4'h0;
            ram_we     <= 1'b0;
            lcd_update <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (power) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (send) begin
                        opcode   <= dec.opcode;
                        sinalImm <= dec.sinal;
                        Imm      <= dec.imm;
                        addr1    <= dec.addr1;
                        addr2    <= dec.addr2;
                        addr_wr  <= dec.addr_wr;
                        err      <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (decoded) begin
                        state <= ST_CALC;
                    end else if (timer_expired) begin
                        err   <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_CALC: begin
                    if (calculated) begin
                        state <= ST_DISPLAY_STORE;
                        // Outputs are registered, so the store-cycle strobes are set on entry.
                        case (opcode_t'(opcode))
                            OP_CLEAR: begin
                                ram_we     <= 1'b1;
                                lcd_update <= 1'b0;
                                addr_wr    <= 4'h0;
                            end
                            OP_DISPLAY: begin
                                ram_we     <= 1'b0;
                                lcd_update <= 1'b1;
                            end
                            default: begin
                                ram_we     <= 1'b1;
                                lcd_update <= 1'b1;
                            end
                        endcase
                    end else if (timer_expired) begin
                        err   <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_DISPLAY_STORE: begin
                    if ((opcode == OP_CLEAR) && (addr_wr != LAST_ADDR)) begin
                        addr_wr    <= addr_wr + 4'h1;
                        lcd_update <= (addr_wr == (LAST_ADDR - 4'h1));
                    end else begin
                        ram_we     <= 1'b0;
                        lcd_update <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_control_unit.sv
// Bench for module_control_unit: cycle-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_module_control_unit;

    localparam int HS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        power = 1'b0;
    logic        send = 1'b0;
    logic [17:0] instr = 18'h0;
    logic        decoded = 1'b0;
    logic        calculated = 1'b0;
    logic [2:0]  stateCPU;
    logic [2:0]  opcode;
    logic        sinalImm;
    logic [5:0]  Imm;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [3:0]  addr_wr;
    logic        ram_we;
    logic        lcd_update;
    logic        err;

    always #5 clk = ~clk;

    module_control_unit #(.HS_TIMEOUT(HS)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .send(send), .instr(instr),
        .decoded(decoded), .calculated(calculated), .stateCPU(stateCPU),
        .opcode(opcode), .sinalImm(sinalImm), .Imm(Imm), .addr1(addr1),
        .addr2(addr2), .addr_wr(addr_wr), .ram_we(ram_we),
        .lcd_update(lcd_update), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0=off 1=fetch 2=decode 3=calc 4=store; wait = cycles already spent waiting.
    int ms = 0, mwait = 0, mk = 0;
    int mop = 0, msg = 0, mim = 0, ma1 = 0, ma2 = 0, maw = 0, merr = 0;

    task automatic m_clear();
        ms = 0; mwait = 0; mk = 0; merr = 0;
        mop = 0; msg = 0; mim = 0; ma1 = 0; ma2 = 0; maw = 0;
    endtask

    task automatic m_latch(input logic [17:0] i);
        mop = int'(i[17:15]);
        maw = int'(i[14:11]);
        ma1 = int'(i[10:7]);
        ma2 = 0;
        msg = int'(i[6]);
        mim = int'(i[5:0]);
        if (mop == 1 || mop == 3) begin
            ma2 = int'(i[6:3]); msg = 0; mim = 0;
        end else if (mop == 0) begin
            ma1 = 0;
        end else if (mop == 7) begin
            maw = int'(i[10:7]);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_clear();
        else if (power && ms != 0) m_clear();
        else begin
            case (ms)
                0: if (power) ms = 1;
                1: if (send) begin m_latch(instr); merr = 0; ms = 2; mwait = 0; end
                2: if (decoded) begin ms = 3; mwait = 0; end
                   else if (mwait == HS - 1) begin ms = 1; merr = 1; end
                   else mwait++;
                3: if (calculated) begin ms = 4; mk = 0; end
                   else if (mwait == HS - 1) begin ms = 1; merr = 1; end
                   else mwait++;
                default: if (mop == 6 && mk < 15) mk++;
                         else begin if (mop == 6) maw = 15; ms = 1; end
            endcase
        end
    end

    // Monitor bookkeeping used by the directed checks.
    int ncnt = 0, we_cnt = 0, lcd_cnt = 0, lcd_addr = -1;
    int send_n = -1, we_n = -1, err_n = -1;
    int we_addr[32];

    always @(negedge clk) begin
        if (!rst_n) m_clear();
        ncnt++;
        chk("stateCPU", 32'(stateCPU), ms);
        chk("opcode", 32'(opcode), mop);
        chk("sinalImm", 32'(sinalImm), msg);
        chk("Imm", 32'(Imm), mim);
        chk("addr1", 32'(addr1), ma1);
        chk("addr2", 32'(addr2), ma2);
        chk("addr_wr", 32'(addr_wr), (ms == 4 && mop == 6) ? mk : maw);
        chk("ram_we", 32'(ram_we), (ms == 4 && mop != 7) ? 1 : 0);
        chk("lcd_update", 32'(lcd_update), (ms == 4 && (mop != 6 || mk == 15)) ? 1 : 0);
        chk("err", 32'(err), merr);
        if (send && stateCPU == 3'b001) send_n = ncnt;
        if (ram_we === 1'b1) begin
            if (we_cnt < 32) we_addr[we_cnt] = int'(addr_wr);
            we_cnt++;
            we_n = ncnt;
        end
        if (lcd_update === 1'b1) begin lcd_cnt++; lcd_addr = int'(addr_wr); end
        if (err === 1'b1 && err_n < 0) err_n = ncnt;
    end

    // ALU responder: acks decode/calc a programmable number of cycles after state entry.
    bit       alu_en = 1'b0;
    int       d_dly = 1, c_dly = 1, st_age = 0;
    logic [2:0] prev_st = 3'b000;

    always @(posedge clk) begin
        #1;
        if (stateCPU != prev_st) st_age = 0; else st_age++;
        prev_st = stateCPU;
        if (alu_en) begin
            decoded    = (stateCPU == 3'b010) && (st_age == d_dly);
            calculated = (stateCPU == 3'b011) && (st_age == c_dly);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        power = 1'b0;
        send  = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_send(input logic [17:0] i);
        instr = i; send = 1'b1; cyc();
    endtask

    task automatic do_power();
        power = 1'b1; cyc();
    endtask

    task automatic clr_mon();
        we_cnt = 0; lcd_cnt = 0; lcd_addr = -1; send_n = -1; we_n = -1; err_n = -1;
    endtask

    initial begin
        int r;
        cycles(3);
        rst_n = 1'b1;
        chk("reset_state", 32'(stateCPU), 0);
        chk("reset_ram_we", 32'(ram_we), 0);
        do_send(18'h0A5A5);
        cycles(2);
        chk("send_while_off", 32'(stateCPU), 0);
        do_power();
        chk("power_on_fetch", 32'(stateCPU), 1);

        // ADDI dest=3 src1=2 sign=0 imm=5, one-cycle ALU acks.
        alu_en = 1'b1; d_dly = 1; c_dly = 1;
        clr_mon();
        do_send({3'b010, 4'd3, 4'd2, 1'b0, 6'd5});
        cycles(8);
        chk("addi_latency", we_n - send_n, 5);
        chk("addi_we_count", we_cnt, 1);
        chk("addi_we_addr", we_addr[0], 3);
        chk("addi_lcd_count", lcd_cnt, 1);
        chk("addi_back_fetch", 32'(stateCPU), 1);

        // CLEAR sweep.
        clr_mon();
        do_send({3'b110, 4'd5, 4'd0, 7'd0});
        cycles(24);
        chk("clear_we_count", we_cnt, 16);
        for (int i = 0; i < 16; i++) chk("clear_sweep_addr", we_addr[i], i);
        chk("clear_lcd_count", lcd_cnt, 1);
        chk("clear_lcd_addr", lcd_addr, 15);

        // SUB with decode never acknowledged.
        alu_en = 1'b0; decoded = 1'b0; calculated = 1'b0;
        clr_mon();
        do_send({3'b011, 4'd1, 4'd2, 4'd3, 3'd0});
        cycles(12);
        chk("timeout_err_delay", err_n - send_n, 9);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_state", 32'(stateCPU), 1);
        chk("timeout_no_write", we_cnt, 0);
        alu_en = 1'b1;
        do_send({3'b001, 4'd4, 4'd5, 4'd6, 3'd0});
        chk("err_cleared_by_send", 32'(err), 0);
        cycles(8);

        // Power pulse in CALC alongside calculated.
        alu_en = 1'b0; decoded = 1'b0; calculated = 1'b0;
        clr_mon();
        do_send({3'b001, 4'd7, 4'd1, 4'd2, 3'd0});
        decoded = 1'b1; cyc(); decoded = 1'b0;
        chk("in_calc", 32'(stateCPU), 3);
        power = 1'b1; calculated = 1'b1; cyc(); calculated = 1'b0;
        chk("power_abort_off", 32'(stateCPU), 0);
        cycles(4);
        chk("power_abort_no_write", we_cnt, 0);

        // Reset in the middle of a CLEAR sweep.
        alu_en = 1'b1; d_dly = 1; c_dly = 1;
        do_power();
        clr_mon();
        do_send({3'b110, 4'd0, 4'd0, 7'd0});
        cycles(11);
        chk("sweep_at_7", 32'(addr_wr), 7);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(stateCPU), 0);
        chk("async_rst_we", 32'(ram_we), 0);
        chk("async_rst_addr", 32'(addr_wr), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cycles(2);
        do_send({3'b010, 4'd1, 4'd1, 7'd1});
        cycles(3);
        chk("post_rst_stays_off", 32'(stateCPU), 0);
        chk("post_rst_writes", we_cnt, 7);

        // DISPLAY src1=9.
        do_power();
        clr_mon();
        do_send({3'b111, 4'd2, 4'd9, 7'd0});
        cycles(8);
        chk("display_no_write", we_cnt, 0);
        chk("display_lcd_count", lcd_cnt, 1);
        chk("display_lcd_addr", lcd_addr, 9);

        // Randomized traffic: power toggles, dropped sends, varying ack delays, timeouts, resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (stateCPU == 3'b000 && r < 30) power = 1'b1;
            else if (r < 2) power = 1'b1;
            else if (r == 2 && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0; cyc(); rst_n = 1'b1;
            end else if (r < 40) begin
                instr = 18'($urandom);
                if ($urandom_range(0, 5) == 0) instr[17:15] = 3'b110;
                send  = 1'b1;
                d_dly = $urandom_range(0, 9);
                c_dly = $urandom_range(0, 9);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
